// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI frame sequencer.
//               - state_t        : sequencer states (IDLE / ACTIVE / GAP)
//               - DATA_W_DEFAULT : default frame length in bits
//               - MIN_DIVISOR    : smallest baud-rate divisor that may start
//                                  a frame
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int MIN_DIVISOR    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : spi_shift_reg
// Description : Transmit/receive shift registers for one SPI frame.
//               Ports:
//                 clk, rst        clock / synchronous active-high reset
//                 i_load          parallel load of i_load_data into tx
//                 i_load_data     byte to transmit
//                 i_lsbfe         1 = LSB first, 0 = MSB first
//                 i_shift         advance tx, shift i_miso into rx
//                 i_miso          serial input bit
//                 o_load_bit      first bit of i_load_data in the chosen order
//                 o_tx_bit        bit currently at the tx pointer
//                 o_tx_next_bit   bit at the pointer after the next shift
//                 o_rx_next       rx contents once i_miso is shifted in
// Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_lsbfe,
    input  logic              i_shift,
    input  logic              i_miso,
    output logic              o_load_bit,
    output logic              o_tx_bit,
    output logic              o_tx_next_bit,
    output logic [DATA_W-1:0] o_rx_next
);

    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [DATA_W-1:0] w_tx_shifted;

    // The outgoing bit always sits at one end of r_tx, so the pointer is
    // advanced by shifting toward that end.
    assign w_tx_shifted  = i_lsbfe ? {1'b0, r_tx[DATA_W-1:1]} : {r_tx[DATA_W-2:0], 1'b0};
    assign o_tx_bit      = i_lsbfe ? r_tx[0] : r_tx[DATA_W-1];
    assign o_tx_next_bit = i_lsbfe ? r_tx[1] : r_tx[DATA_W-2];
    assign o_load_bit    = i_lsbfe ? i_load_data[0] : i_load_data[DATA_W-1];
    assign o_rx_next     = i_lsbfe ? {i_miso, r_rx[DATA_W-1:1]} : {r_rx[DATA_W-2:0], i_miso};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx <= '0;
            r_rx <= '0;
        end else if (i_load) begin
            r_tx <= i_load_data;
            r_rx <= '0;
        end else if (i_shift) begin
            r_tx <= w_tx_shifted;
            r_rx <= o_rx_next;
        end
    end

endmodule : spi_shift_reg
`default_nettype wire

// File: rtl/spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_xfer_ctrl
// Description : Master-side SPI frame sequencer. Holds one transmit byte,
//               drives slave-select and MOSI from the baud generator's
//               send/sample flags, assembles the received byte and pulses
//               spif_o at frame end.
//               Ports:
//                 PCLK, PRESET            clock / sync active-high reset
//                 spe_i                   enable; low aborts any frame
//                 cpol_i, cpha_i, lsbfe_i mode and bit order
//                 send_data_i, data_mosi_i  holding-buffer write
//                 BaudRateDivisor_i       PCLK cycles per SCLK period
//                 mosi_send_sclk*_i       send flags (two phase groups)
//                 miso_receive_sclk*_i    sample flags (two phase groups)
//                 miso_i                  serial input
//                 ss_o, mosi_o, tip_o     serial side status
//                 sptef_o, spif_o         buffer empty / frame complete
//                 data_miso_o             last received byte
//                 cfg_err_o               frame refused, divisor too small
// Revision    : 1.0 - initial release
// ============================================================================
module spi_xfer_ctrl
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DIV_W  = 12
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              spe_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsbfe_i,
    input  logic              send_data_i,
    input  logic [DATA_W-1:0] data_mosi_i,
    input  logic [DIV_W-1:0]  BaudRateDivisor_i,
    input  logic              mosi_send_sclk_i,
    input  logic              mosi_send_sclk0_i,
    input  logic              miso_receive_sclk_i,
    input  logic              miso_receive_sclk0_i,
    input  logic              miso_i,
    output logic              ss_o,
    output logic              mosi_o,
    output logic              tip_o,
    output logic              sptef_o,
    output logic              spif_o,
    output logic [DATA_W-1:0] data_miso_o,
    output logic              cfg_err_o
);

    localparam int                 CNT_W      = $clog2(DATA_W);
    localparam logic [CNT_W-1:0]   c_LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]   c_CNT_ONE  = CNT_W'(1);
    localparam logic [DIV_W-2:0]   c_GAP_ONE  = (DIV_W-1)'(1);

    state_t            r_state;
    logic              r_ss;
    logic              r_mosi;
    logic              r_sptef;
    logic              r_spif;
    logic              r_cfg_err;
    logic [DATA_W-1:0] r_data_miso;
    logic [DATA_W-1:0] r_hold;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DIV_W-2:0]  r_gap_cnt;

    logic              w_send;
    logic              w_sample;
    logic              w_div_ok;
    logic              w_start;
    logic              w_shift;
    logic [DIV_W-2:0]  w_half;
    logic              w_load_bit;
    logic              w_tx_bit;
    logic              w_tx_next_bit;
    logic [DATA_W-1:0] w_rx_next;

    // Modes 1 and 2 use the falling-group flags, modes 0 and 3 the rising group.
    assign w_send   = (cpol_i ^ cpha_i) ? mosi_send_sclk0_i    : mosi_send_sclk_i;
    assign w_sample = (cpol_i ^ cpha_i) ? miso_receive_sclk0_i : miso_receive_sclk_i;

    assign w_div_ok = (BaudRateDivisor_i >= DIV_W'(MIN_DIVISOR));
    assign w_half   = BaudRateDivisor_i[DIV_W-1:1];
    assign w_start  = (r_state == ST_IDLE) && spe_i && !r_sptef && w_div_ok;
    assign w_shift  = (r_state == ST_ACTIVE) && spe_i && w_sample;

    spi_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift_reg (
        .clk           (PCLK),
        .rst           (PRESET),
        .i_load        (w_start),
        .i_load_data   (r_hold),
        .i_lsbfe       (lsbfe_i),
        .i_shift       (w_shift),
        .i_miso        (miso_i),
        .o_load_bit    (w_load_bit),
        .o_tx_bit      (w_tx_bit),
        .o_tx_next_bit (w_tx_next_bit),
        .o_rx_next     (w_rx_next)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state     <= ST_IDLE;
            r_ss        <= 1'b1;
            r_mosi      <= 1'b0;
            r_sptef     <= 1'b1;
            r_spif      <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_data_miso <= '0;
            r_hold      <= '0;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
        end else begin
            r_spif    <= 1'b0;
            r_cfg_err <= 1'b0;
            if (!spe_i) begin
                r_state <= ST_IDLE;
                r_ss    <= 1'b1;
                r_sptef <= 1'b1;
                r_hold  <= '0;
            end else begin
                // A start or refusal only happens while the buffer is full,
                // so it never collides with an accepted write.
                if (r_sptef && send_data_i) begin
                    r_hold  <= data_mosi_i;
                    r_sptef <= 1'b0;
                end
                case (r_state)
                    ST_IDLE: begin
                        if (!r_sptef) begin
                            r_sptef <= 1'b1;
                            if (w_div_ok) begin
                                r_ss      <= 1'b0;
                                r_mosi    <= w_load_bit;
                                r_bit_cnt <= '0;
                                r_state   <= ST_ACTIVE;
                            end else begin
                                r_cfg_err <= 1'b1;
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        // With a coincident sample the pointer has already
                        // moved, so the following bit goes out.
                        if (w_send) begin
                            r_mosi <= w_sample ? w_tx_next_bit : w_tx_bit;
                        end
                        if (w_sample) begin
                            r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_data_miso <= w_rx_next;
                                r_spif      <= 1'b1;
                                r_ss        <= 1'b1;
                                r_gap_cnt   <= w_half - c_GAP_ONE;
                                r_state     <= ST_GAP;
                            end
                        end
                    end
                    ST_GAP: begin
                        // The IDLE cycle that follows also keeps ss high, so
                        // GAP ends one count early to give divisor/2 in total.
                        if (r_gap_cnt <= c_GAP_ONE) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt - c_GAP_ONE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign ss_o        = r_ss;
    assign tip_o       = !r_ss;
    assign mosi_o      = r_mosi;
    assign sptef_o     = r_sptef;
    assign spif_o      = r_spif;
    assign cfg_err_o   = r_cfg_err;
    assign data_miso_o = r_data_miso;

endmodule : spi_xfer_ctrl
`default_nettype wire

// File: tb/tb_spi_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_xfer_ctrl
// Description : Self-checking bench for spi_xfer_ctrl. Drives the baud
//               generator flags, queues each expected received byte when
//               the write is issued and compares it on every spif_o pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_xfer_ctrl;

    localparam int HALF = 4;

    logic        PCLK;
    logic        PRESET;
    logic        spe_i;
    logic        cpol_i;
    logic        cpha_i;
    logic        lsbfe_i;
    logic        send_data_i;
    logic [7:0]  data_mosi_i;
    logic [11:0] BaudRateDivisor_i;
    logic        mosi_send_sclk_i;
    logic        mosi_send_sclk0_i;
    logic        miso_receive_sclk_i;
    logic        miso_receive_sclk0_i;
    logic        miso_i;
    logic        ss_o;
    logic        mosi_o;
    logic        tip_o;
    logic        sptef_o;
    logic        spif_o;
    logic [7:0]  data_miso_o;
    logic        cfg_err_o;

    logic        loop_en;
    logic        tie_val;
    int          checks;
    int          failures;
    int          spif_cnt;
    logic [7:0]  last_rx;
    logic [7:0]  exp_q[$];

    assign miso_i = loop_en ? mosi_o : tie_val;

    spi_xfer_ctrl #(
        .DATA_W (8),
        .DIV_W  (12)
    ) dut (
        .PCLK                 (PCLK),
        .PRESET               (PRESET),
        .spe_i                (spe_i),
        .cpol_i               (cpol_i),
        .cpha_i               (cpha_i),
        .lsbfe_i              (lsbfe_i),
        .send_data_i          (send_data_i),
        .data_mosi_i          (data_mosi_i),
        .BaudRateDivisor_i    (BaudRateDivisor_i),
        .mosi_send_sclk_i     (mosi_send_sclk_i),
        .mosi_send_sclk0_i    (mosi_send_sclk0_i),
        .miso_receive_sclk_i  (miso_receive_sclk_i),
        .miso_receive_sclk0_i (miso_receive_sclk0_i),
        .miso_i               (miso_i),
        .ss_o                 (ss_o),
        .mosi_o               (mosi_o),
        .tip_o                (tip_o),
        .sptef_o              (sptef_o),
        .spif_o               (spif_o),
        .data_miso_o          (data_miso_o),
        .cfg_err_o            (cfg_err_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Order in which the bits of d should appear on the wire.
    function automatic logic [7:0] wire_order(input logic [7:0] d, input logic lsb);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = lsb ? d[i] : d[7-i];
        return r;
    endfunction

    task automatic write_byte(input logic [7:0] d, input bit push, input logic [7:0] exp_rx);
        send_data_i = 1'b1;
        data_mosi_i = d;
        if (push) exp_q.push_back(exp_rx);
        tick();
        send_data_i = 1'b0;
    endtask

    task automatic pulse(input bit smp);
        if (cpol_i ^ cpha_i) begin
            if (smp) miso_receive_sclk0_i = 1'b1; else mosi_send_sclk0_i = 1'b1;
        end else begin
            if (smp) miso_receive_sclk_i = 1'b1; else mosi_send_sclk_i = 1'b1;
        end
        tick();
        mosi_send_sclk_i     = 1'b0;
        mosi_send_sclk0_i    = 1'b0;
        miso_receive_sclk_i  = 1'b0;
        miso_receive_sclk0_i = 1'b0;
    endtask

    task automatic drive_frame(input int nbits, input logic [7:0] data, input bit full);
        int         t;
        logic [7:0] seq;
        seq = '0;
        t   = 0;
        while (ss_o !== 1'b0 && t < 40) begin
            tick();
            t++;
        end
        check_eq("frame_start_ss", {31'b0, ss_o}, 32'd0);
        if (ss_o !== 1'b0) return;
        for (int b = 0; b < nbits; b++) begin
            if (cpha_i) begin
                pulse(1'b0);
                idle(HALF - 1);
            end else begin
                idle(HALF - 1);
            end
            seq[b] = mosi_o;
            if (full && b == nbits - 1) check_eq("ss_low_last", {31'b0, ss_o}, 32'd0);
            pulse(1'b1);
            if (b != nbits - 1) begin
                idle(HALF - 1);
                if (!cpha_i) pulse(1'b0);
            end
        end
        if (full) begin
            check_eq("spif_pulse", {31'b0, spif_o}, 32'd1);
            check_eq("ss_high_end", {31'b0, ss_o}, 32'd1);
            check_eq("mosi_seq", {24'b0, seq}, {24'b0, wire_order(data, lsbfe_i)});
        end
    endtask

    // Scoreboard: every frame completion consumes one queued expectation.
    always @(negedge PCLK) begin
        if (!PRESET && spif_o) begin
            spif_cnt++;
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_spif", 32'd1, 32'd0);
            end else begin
                last_rx = exp_q.pop_front();
                check_eq("sb_rx", {24'b0, data_miso_o}, {24'b0, last_rx});
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        spif_cnt = 0;
        last_rx  = '0;
        PRESET = 1'b1;
        spe_i = 1'b1;
        cpol_i = 1'b0;
        cpha_i = 1'b0;
        lsbfe_i = 1'b0;
        send_data_i = 1'b0;
        data_mosi_i = '0;
        BaudRateDivisor_i = 12'd8;
        mosi_send_sclk_i = 1'b0;
        mosi_send_sclk0_i = 1'b0;
        miso_receive_sclk_i = 1'b0;
        miso_receive_sclk0_i = 1'b0;
        loop_en = 1'b1;
        tie_val = 1'b0;
        idle(3);
        PRESET = 1'b0;

        check_eq("rst_ss", {31'b0, ss_o}, 32'd1);
        check_eq("rst_mosi", {31'b0, mosi_o}, 32'd0);
        check_eq("rst_tip", {31'b0, tip_o}, 32'd0);
        check_eq("rst_sptef", {31'b0, sptef_o}, 32'd1);
        check_eq("rst_spif", {31'b0, spif_o}, 32'd0);
        check_eq("rst_cfg_err", {31'b0, cfg_err_o}, 32'd0);
        check_eq("rst_data", {24'b0, data_miso_o}, 32'd0);
        idle(2);

        // Mode 0, MSB first, loopback, with start latency checks
        write_byte(8'hA5, 1'b1, 8'hA5);
        check_eq("lat_sptef_full", {31'b0, sptef_o}, 32'd0);
        check_eq("lat_ss_still_high", {31'b0, ss_o}, 32'd1);
        tick();
        check_eq("lat_ss_low", {31'b0, ss_o}, 32'd0);
        check_eq("lat_sptef_empty", {31'b0, sptef_o}, 32'd1);
        check_eq("lat_first_bit", {31'b0, mosi_o}, 32'd1);
        check_eq("lat_tip", {31'b0, tip_o}, 32'd1);
        drive_frame(8, 8'hA5, 1'b1);
        idle(6);
        check_eq("m0_spif_once", spif_cnt, 32'd1);

        // Mode 3, LSB first, MISO tied high
        cpol_i = 1'b1; cpha_i = 1'b1; lsbfe_i = 1'b1;
        loop_en = 1'b0; tie_val = 1'b1;
        write_byte(8'h01, 1'b1, 8'hFF);
        drive_frame(8, 8'h01, 1'b1);
        idle(6);

        // Mode 1 uses the falling-group flags
        cpol_i = 1'b0; cpha_i = 1'b1; lsbfe_i = 1'b0;
        loop_en = 1'b1;
        write_byte(8'h96, 1'b1, 8'h96);
        drive_frame(8, 8'h96, 1'b1);
        idle(6);

        // Back-to-back frames, mode 0; third write must be dropped
        cpol_i = 1'b0; cpha_i = 1'b0;
        write_byte(8'h3C, 1'b1, 8'h3C);
        tick();
        check_eq("b2b_tip", {31'b0, tip_o}, 32'd1);
        write_byte(8'hC3, 1'b1, 8'hC3);
        check_eq("b2b_sptef_full", {31'b0, sptef_o}, 32'd0);
        write_byte(8'hFF, 1'b0, 8'h00);
        drive_frame(8, 8'h3C, 1'b1);
        n = 0;
        while (ss_o === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        check_eq("b2b_gap_cycles", n, 32'd4);
        drive_frame(8, 8'hC3, 1'b1);
        idle(10);
        check_eq("b2b_no_third", {31'b0, tip_o}, 32'd0);
        check_eq("b2b_sptef_empty", {31'b0, sptef_o}, 32'd1);
        check_eq("b2b_spif_total", spif_cnt, 32'd5);

        // Divisor below minimum refuses the frame
        BaudRateDivisor_i = 12'd2;
        write_byte(8'h55, 1'b0, 8'h00);
        tick();
        check_eq("div2_cfg_err", {31'b0, cfg_err_o}, 32'd1);
        check_eq("div2_sptef", {31'b0, sptef_o}, 32'd1);
        check_eq("div2_ss", {31'b0, ss_o}, 32'd1);
        tick();
        check_eq("div2_cfg_err_off", {31'b0, cfg_err_o}, 32'd0);
        idle(5);
        check_eq("div2_ss_stays", {31'b0, ss_o}, 32'd1);
        BaudRateDivisor_i = 12'd8;
        idle(2);

        // Abort after the 4th sample with a byte pending in the buffer
        write_byte(8'h5A, 1'b0, 8'h00);
        tick();
        write_byte(8'h77, 1'b0, 8'h00);
        drive_frame(4, 8'h5A, 1'b0);
        spe_i = 1'b0;
        tick();
        spe_i = 1'b1;
        check_eq("abort_ss", {31'b0, ss_o}, 32'd1);
        check_eq("abort_spif", {31'b0, spif_o}, 32'd0);
        check_eq("abort_sptef", {31'b0, sptef_o}, 32'd1);
        check_eq("abort_data_kept", {24'b0, data_miso_o}, {24'b0, last_rx});
        idle(6);
        check_eq("abort_hold_cleared", {31'b0, tip_o}, 32'd0);

        // Reset mid-frame, then a fresh frame
        write_byte(8'h33, 1'b0, 8'h00);
        drive_frame(3, 8'h33, 1'b0);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        check_eq("mrst_ss", {31'b0, ss_o}, 32'd1);
        check_eq("mrst_mosi", {31'b0, mosi_o}, 32'd0);
        check_eq("mrst_tip", {31'b0, tip_o}, 32'd0);
        check_eq("mrst_sptef", {31'b0, sptef_o}, 32'd1);
        check_eq("mrst_spif", {31'b0, spif_o}, 32'd0);
        check_eq("mrst_cfg_err", {31'b0, cfg_err_o}, 32'd0);
        check_eq("mrst_data", {24'b0, data_miso_o}, 32'd0);
        idle(2);
        write_byte(8'h81, 1'b1, 8'h81);
        drive_frame(8, 8'h81, 1'b1);
        idle(6);

        check_eq("sb_drained", exp_q.size(), 32'd0);
        check_eq("spif_total", spif_cnt, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_spi_xfer_ctrl
`default_nettype wire

// File: doc/spi_xfer_ctrl.md
# spi_xfer_ctrl

Master-side SPI frame sequencer that sits between the APB register slice and the baud-rate generator. It owns slave-select, a one-deep transmit holding buffer, and the transmit/receive shift registers. It uses the generator's per-edge send/sample flags to shift exactly DATA_W bits per frame, then reports completion with a one-cycle `spif_o` pulse.

## Interface
- DATA_W, 8, frame length in bits
- DIV_W, 12, width of the baud-rate divisor input
- PCLK  in  1  clock
- PRESET  in  1  reset; synchronous, active-high
- spe_i  in  1  SPI enable; low aborts any frame
- cpol_i, cpha_i  in  1 each  clock polarity / phase
- lsbfe_i  in  1  1 = LSB first, 0 = MSB first
- send_data_i  in  1  one-cycle write strobe for data_mosi_i
- data_mosi_i  in  DATA_W  transmit byte
- BaudRateDivisor_i  in  DIV_W  PCLK cycles per SCLK period
- mosi_send_sclk_i, mosi_send_sclk0_i  in  1 each  send flags (rising-group / falling-group)
- miso_receive_sclk_i, miso_receive_sclk0_i  in  1 each  sample flags (rising-group / falling-group)
- miso_i  in  1  serial input
- ss_o  out  1  slave select, active-low
- mosi_o  out  1  serial output
- tip_o  out  1  transfer in progress (= !ss_o)
- sptef_o  out  1  holding buffer empty
- spif_o  out  1  one-cycle frame-complete pulse
- data_miso_o  out  DATA_W  last received byte
- cfg_err_o  out  1  one-cycle pulse: frame refused because divisor < 4

## Operation
- Flag selection:
  - cpol_i ^ cpha_i = 1: send = mosi_send_sclk0_i, sample = miso_receive_sclk0_i.
  - Otherwise: send = mosi_send_sclk_i, sample = miso_receive_sclk_i.
  - The unselected pair is ignored.
- Holding buffer:
  - send_data_i with sptef_o = 1 loads data_mosi_i and clears sptef_o.
  - send_data_i with sptef_o = 0 is dropped silently; the holding buffer is unchanged.
- States: IDLE, ACTIVE, GAP.
- IDLE:
  - Holding full, spe_i = 1 and divisor ≥ 4: load the shifter, set sptef_o = 1, ss_o = 0, set mosi_o to the first bit, clear bit_cnt, go to ACTIVE.
  - Holding full and divisor < 4: discard the holding buffer, set sptef_o = 1, pulse cfg_err_o, stay in IDLE.
- ACTIVE:
  - On send: mosi_o ← current tx bit.
  - On sample: shift miso_i into rx (direction set by lsbfe_i), advance the tx pointer, bit_cnt++.
  - Send and sample in the same cycle: process sample first, then mosi_o takes the new pointer bit.
  - Sample with bit_cnt = DATA_W−1: data_miso_o ← assembled byte, spif_o = 1, ss_o = 1, go to GAP.
- GAP:
  - ss_o stays high for BaudRateDivisor_i/2 cycles, then the FSM goes to IDLE.
  - A pending holding byte starts on the IDLE cycle immediately after GAP.
- Abort: spe_i = 0 in any state → next cycle ss_o = 1, IDLE, holding cleared, sptef_o = 1, no spif_o, data_miso_o unchanged.
- Configuration timing: cpol_i, cpha_i and lsbfe_i are sampled every cycle. They must be held stable while tip_o = 1; behaviour is undefined if they change mid-frame.

## Timing
- Reset values: ss_o = 1, mosi_o = 0, tip_o = 0, sptef_o = 1, spif_o = 0, cfg_err_o = 0, data_miso_o = 0; FSM in IDLE.
- Reset asserted mid-frame gives the same reset values on the next edge.
- Start latency:
  - send_data_i at cycle N → sptef_o = 0 at N+1.
  - ss_o = 0, sptef_o = 1 and first mosi_o bit at N+2.
- Completion: final sample flag at cycle M → spif_o high and data_miso_o valid at M+1, ss_o = 1 at M+1.
- Back-to-back frames: minimum ss_o-high time = max(1, BaudRateDivisor_i/2) cycles.
- Simultaneous events:
  - send_data_i in the same cycle as the final sample is accepted when sptef_o = 1.
  - spe_i = 0 has priority over every other event.
- Arithmetic:
  - bit_cnt width = $clog2(DATA_W).
  - The GAP counter is DIV_W−1 bits and counts down from divisor/2 − 1.

## Structure
- Package spi_pkg:
  - state enum (IDLE, ACTIVE, GAP)
  - DATA_W default
  - MIN_DIVISOR = 4 constant
- Sub-module spi_shift_reg:
  - parallel load, lsbfe-aware tx bit select, rx shift-in
  - DATA_W parameter
  - instantiated once
- The FSM, holding buffer and GAP counter stay in spi_xfer_ctrl.

## Test plan
- Mode 0, lsbfe = 0, divisor 8: write 0xA5 with miso looped to mosi → eight samples; spif_o pulses once, data_miso_o = 0xA5, ss_o low for exactly one frame.
- Mode 3, lsbfe = 1: write 0x01 with miso tied 1 → mosi_o sequence 1,0,0,0,0,0,0,0; data_miso_o = 0xFF.
- Back-to-back: write 0x3C, then write 0xC3 while tip_o = 1:
  - both frames complete and ss_o is high for divisor/2 cycles between them
  - a third write while sptef_o = 0 is dropped.
- Divisor 2 (sppr = 0, spr = 0): write 0x55 → cfg_err_o pulses, ss_o never falls, sptef_o returns to 1.
- Drop spe_i after the 4th sample → ss_o = 1 next cycle, no spif_o, data_miso_o keeps its prior value.
- Assert PRESET mid-frame → all outputs at reset values next cycle; a fresh write completes normally.
